fpu_req_arbiter: RTL and testbench

- Shares one pipelined fpu instance (ports Clock, Reset, A, B, Sel, Error, Overflow, Y) between two requesters.
- Arbitrates requests round-robin and drives the fpu operand/Sel inputs.
- Tracks in-flight operations with a tag pipeline and returns each result to its owner through a per-requester response FIFO.
- Issue is credit-limited so a stalled requester can never lose a result or block the other requester.

---
 rtl/fpu_req_arbiter.sv | 108 ++++++++++
 tb/tb_fpu_req_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_req_arbiter.sv
// fpu_req_arbiter: round-robin sharing of one pipelined fpu between two requesters,
// with tag-tracked results returned in order through credit-limited response FIFOs.
module fpu_req_arbiter #(
    parameter int FPU_LAT   = 3,
    parameter int RSP_DEPTH = 4
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [31:0] r0_a,
    input  logic [31:0] r0_b,
    input  logic [1:0]  r0_sel,
    output logic        r0_rsp_valid,
    input  logic        r0_rsp_ready,
    output logic [31:0] r0_y,
    output logic        r0_ovf,
    output logic        r0_err,
    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [31:0] r1_a,
    input  logic [31:0] r1_b,
    input  logic [1:0]  r1_sel,
    output logic        r1_rsp_valid,
    input  logic        r1_rsp_ready,
    output logic [31:0] r1_y,
    output logic        r1_ovf,
    output logic        r1_err,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic [1:0]  fpu_sel,
    input  logic [31:0] fpu_y,
    input  logic        fpu_ovf,
    input  logic        fpu_err,
    output logic        idle
);
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int PW = RSP_DEPTH > 1 ? $clog2(RSP_DEPTH) : 1;
    logic [1:0]         valid, rsp_ready, elig, grant, push, pop;
    logic               last_grant;
    logic [FPU_LAT-1:0] tag_v, tag_id;
    logic [CW-1:0]      infl [2];
    logic [CW-1:0]      cnt [2];
    logic [PW-1:0]      rd [2];
    logic [PW-1:0]      wr [2];
    logic [33:0]        mem [2][RSP_DEPTH];
    assign valid     = {r1_valid, r0_valid};
    assign rsp_ready = {r1_rsp_ready, r0_rsp_ready};
    // credit = slots not yet claimed by in-flight ops or queued results
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            elig[i] = valid[i] && (CW+1)'(infl[i]) + (CW+1)'(cnt[i]) < (CW+1)'(RSP_DEPTH);
            push[i] = tag_v[FPU_LAT-1] && tag_id[FPU_LAT-1] == 1'(i);
            pop[i]  = cnt[i] != '0 && rsp_ready[i];
        end
    end
    assign grant[0] = Reset && elig[0] && (!elig[1] || last_grant);
    assign grant[1] = Reset && elig[1] && (!elig[0] || !last_grant);
    assign r0_ready = grant[0];
    assign r1_ready = grant[1];
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            last_grant <= 1'b1;
            fpu_a      <= '0;
            fpu_b      <= '0;
            fpu_sel    <= '0;
            tag_v      <= '0;
            tag_id     <= '0;
        end else begin
            tag_v  <= (tag_v << 1) | FPU_LAT'(|grant);
            tag_id <= (tag_id << 1) | FPU_LAT'(grant[1]);
            if (|grant) begin
                last_grant <= grant[1];
                fpu_a      <= grant[1] ? r1_a : r0_a;
                fpu_b      <= grant[1] ? r1_b : r0_b;
                fpu_sel    <= grant[1] ? r1_sel : r0_sel;
            end
        end
    end
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 2; i++) begin
                infl[i] <= '0;
                cnt[i]  <= '0;
                rd[i]   <= '0;
                wr[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                infl[i] <= infl[i] + CW'(grant[i]) - CW'(push[i]);
                cnt[i]  <= cnt[i] + CW'(push[i]) - CW'(pop[i]);
                if (push[i])
                    wr[i] <= wr[i] == PW'(RSP_DEPTH - 1) ? '0 : wr[i] + PW'(1);
                if (pop[i])
                    rd[i] <= rd[i] == PW'(RSP_DEPTH - 1) ? '0 : rd[i] + PW'(1);
            end
        end
    end
    always_ff @(posedge Clock) begin
        for (int i = 0; i < 2; i++)
            if (push[i]) mem[i][wr[i]] <= {fpu_y, fpu_ovf, fpu_err};
    end
    assign r0_rsp_valid              = cnt[0] != '0;
    assign r1_rsp_valid              = cnt[1] != '0;
    assign {r0_y, r0_ovf, r0_err}    = mem[0][rd[0]];
    assign {r1_y, r1_ovf, r1_err}    = mem[1][rd[1]];
    assign idle = tag_v == '0 && cnt[0] == '0 && cnt[1] == '0;
endmodule

// File: tb/tb_fpu_req_arbiter.sv
// tb_fpu_req_arbiter: emulated pipelined fpu plus a queue-based reference model
// of arbitration, credits and per-requester result ordering.
module tb_fpu_req_arbiter;
    localparam int FPU_LAT = 3, RSP_DEPTH = 4;
    logic Clock = 1'b0, Reset = 1'b1;
    logic r0_valid = 0, r0_ready, r0_rsp_valid, r0_rsp_ready = 0, r0_ovf, r0_err;
    logic r1_valid = 0, r1_ready, r1_rsp_valid, r1_rsp_ready = 0, r1_ovf, r1_err;
    logic [31:0] r0_a = 0, r0_b = 0, r0_y, r1_a = 0, r1_b = 0, r1_y;
    logic [1:0]  r0_sel = 0, r1_sel = 0, fpu_sel;
    logic [31:0] fpu_a, fpu_b, fpu_y;
    logic fpu_ovf, fpu_err, idle;
    int total = 0, bad = 0;

    always #5 Clock = ~Clock;

    fpu_req_arbiter #(.FPU_LAT(FPU_LAT), .RSP_DEPTH(RSP_DEPTH)) dut (
        .Clock(Clock), .Reset(Reset),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_sel(r0_sel),
        .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready), .r0_y(r0_y), .r0_ovf(r0_ovf), .r0_err(r0_err),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_sel(r1_sel),
        .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready), .r1_y(r1_y), .r1_ovf(r1_ovf), .r1_err(r1_err),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_sel(fpu_sel),
        .fpu_y(fpu_y), .fpu_ovf(fpu_ovf), .fpu_err(fpu_err), .idle(idle));

    function automatic real s2r(input logic [31:0] s);
        if (s[30:23] == 8'd0) return 0.0;
        return $bitstoreal({s[31], {3'b0, s[30:23]} + 11'd896, s[22:0], 29'b0});
    endfunction

    // {y, ovf, err}; real arithmetic on normal operands, truncated back to single
    function automatic logic [33:0] fpu_fn(input logic [31:0] a, input logic [31:0] b, input logic [1:0] s);
        real x, y, r;
        logic [63:0] d;
        logic [10:0] e;
        x = s2r(a);
        y = s2r(b);
        if (s == 2'b11 && y == 0.0) return {32'h7fc00000, 2'b01};
        r = s == 2'b00 ? x + y : s == 2'b01 ? x - y : s == 2'b10 ? x * y : x / y;
        d = $realtobits(r);
        e = d[62:52];
        if (e > 11'd1150) return {d[63], 8'hff, 23'h0, 2'b10};
        if (e < 11'd897) return {d[63], 31'h0, 2'b00};
        return {d[63], 8'(e - 11'd896), d[51:29], 2'b00};
    endfunction

    logic [33:0] fp [FPU_LAT-1];
    always @(posedge Clock) begin
        fp[0] <= fpu_fn(fpu_a, fpu_b, fpu_sel);
        for (int i = 1; i < FPU_LAT - 1; i++) fp[i] <= fp[i-1];
    end
    assign {fpu_y, fpu_ovf, fpu_err} = fp[FPU_LAT-2];

    always @(negedge Clock)
        if (Reset)
            for (int i = 0; i < 2; i++)
                if (dut.push[i] && dut.cnt[i] == 3'(RSP_DEPTH)) begin
                    $display("FAIL push_full id=%0d got=full required=not_full", i);
                    bad++;
                end

    typedef struct {int due; bit id; logic [33:0] r;} iss_t;
    iss_t iss[$];
    logic [33:0] q0[$], q1[$];
    bit mlast = 1, g0, g1;
    logic [31:0] mfa = 0, mfb = 0;
    logic [1:0] msel = 0;
    int cyc = 0;
    bit obs0, obs1, obsv0, obsv1, oidle;
    logic [33:0] oy0, oy1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h required=%0h", name, got, exp);
        end
    endtask

    function automatic int infl(input bit id);
        int n = 0;
        foreach (iss[k]) if (iss[k].id == id) n++;
        return n;
    endfunction

    function automatic logic [31:0] rfp();
        return {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
    endfunction

    task automatic step();
        bit e0, e1;
        @(negedge Clock);
        #1;
        e0 = r0_valid && infl(0) + q0.size() < RSP_DEPTH;
        e1 = r1_valid && infl(1) + q1.size() < RSP_DEPTH;
        g0 = e0 && (!e1 || mlast);
        g1 = e1 && (!e0 || !mlast);
        chk("r0_ready", 64'(r0_ready), 64'(g0));
        chk("r1_ready", 64'(r1_ready), 64'(g1));
        chk("r0_rsp_valid", 64'(r0_rsp_valid), 64'(q0.size() != 0));
        chk("r1_rsp_valid", 64'(r1_rsp_valid), 64'(q1.size() != 0));
        if (q0.size() != 0) chk("r0_rsp", 64'({r0_y, r0_ovf, r0_err}), 64'(q0[0]));
        if (q1.size() != 0) chk("r1_rsp", 64'({r1_y, r1_ovf, r1_err}), 64'(q1[0]));
        chk("fpu_a", 64'(fpu_a), 64'(mfa));
        chk("fpu_b", 64'(fpu_b), 64'(mfb));
        chk("fpu_sel", 64'(fpu_sel), 64'(msel));
        chk("idle", 64'(idle), 64'(iss.size() == 0 && q0.size() == 0 && q1.size() == 0));
        obs0 = r0_ready; obs1 = r1_ready; obsv0 = r0_rsp_valid; obsv1 = r1_rsp_valid; oidle = idle;
        oy0 = {r0_y, r0_ovf, r0_err}; oy1 = {r1_y, r1_ovf, r1_err};
        @(posedge Clock);
        if (q0.size() != 0 && r0_rsp_ready) void'(q0.pop_front());
        if (q1.size() != 0 && r1_rsp_ready) void'(q1.pop_front());
        if (iss.size() != 0 && iss[0].due == cyc) begin
            iss_t e = iss.pop_front();
            if (e.id) q1.push_back(e.r); else q0.push_back(e.r);
        end
        if (g0 || g1) begin
            iss.push_back('{cyc + FPU_LAT, g1, g1 ? fpu_fn(r1_a, r1_b, r1_sel) : fpu_fn(r0_a, r0_b, r0_sel)});
            mfa = g1 ? r1_a : r0_a;
            mfb = g1 ? r1_b : r0_b;
            msel = g1 ? r1_sel : r0_sel;
            mlast = g1;
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset(input bit v_after);
        #2 Reset = 0;
        #1;
        chk("rst_r0_ready", 64'(r0_ready), 64'(0));
        chk("rst_r1_ready", 64'(r1_ready), 64'(0));
        chk("rst_r0_rsp_valid", 64'(r0_rsp_valid), 64'(0));
        chk("rst_r1_rsp_valid", 64'(r1_rsp_valid), 64'(0));
        chk("rst_idle", 64'(idle), 64'(1));
        chk("rst_fpu", 64'({fpu_a, fpu_b, fpu_sel}), 64'(0));
        iss.delete(); q0.delete(); q1.delete();
        mlast = 1; mfa = 0; mfb = 0; msel = 0;
        r0_valid = v_after; r1_valid = v_after;
        @(posedge Clock); @(posedge Clock);
        #3 Reset = 1;
    endtask

    task automatic idle_in();
        r0_valid = 0; r1_valid = 0; r0_rsp_ready = 1; r1_rsp_ready = 1;
    endtask

    task automatic rnd_ops();
        r0_a = rfp(); r0_b = rfp(); r0_sel = 2'($urandom);
        r1_a = rfp(); r1_b = rfp(); r1_sel = 2'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int n0, n1, first;
        logic [33:0] y1;
        int at[$];
        logic [33:0] ad[$];
        do_reset(0);
        idle_in();
        // single add, exact 129+120
        r0_a = 32'h43010000; r0_b = 32'h42f00000; r0_sel = 2'b00; r0_valid = 1;
        step();
        chk("t1_hs", 64'(obs0), 64'(1));
        r0_valid = 0; first = 0; n0 = 0; n1 = 0; y1 = '0;
        for (int i = 1; i <= FPU_LAT + 4; i++) begin
            step();
            if (obsv0) begin n0++; if (first == 0) begin first = i; y1 = oy0; end end
            if (obsv1) n1++;
        end
        chk("t1_lat", 64'(first), 64'(FPU_LAT + 1));
        chk("t1_y", 64'(y1), 64'({32'h43790000, 2'b00}));
        chk("t1_n0", 64'(n0), 64'(1));
        chk("t1_n1", 64'(n1), 64'(0));
        // contention from reset release
        rnd_ops(); r0_rsp_ready = 1; r1_rsp_ready = 1; r0_valid = 1; r1_valid = 1;
        do_reset(1);
        n0 = 0; n1 = 0;
        for (int k = 0; k < 8; k++) begin
            rnd_ops();
            step();
            chk("t2_alt0", 64'(obs0), 64'(k % 2 == 0));
            chk("t2_alt1", 64'(obs1), 64'(k % 2 == 1));
            if (obsv0) n0++;
            if (obsv1) n1++;
        end
        r0_valid = 0; r1_valid = 0;
        repeat (12) begin step(); if (obsv0) n0++; if (obsv1) n1++; end
        chk("t2_n0", 64'(n0), 64'(4));
        chk("t2_n1", 64'(n1), 64'(4));
        // backpressure on r0
        idle_in(); r0_rsp_ready = 0; r0_valid = 1; n0 = 0;
        repeat (10) begin rnd_ops(); step(); if (obs0) n0++; end
        chk("t3_grants", 64'(n0), 64'(RSP_DEPTH));
        r1_valid = 1; n0 = 0; n1 = 0;
        repeat (3) begin rnd_ops(); step(); if (obs0) n0++; if (obs1) n1++; end
        chk("t3_r0_blocked", 64'(n0), 64'(0));
        chk("t3_r1_granted", 64'(n1), 64'(3));
        r1_valid = 0;
        repeat (8) step();
        r0_rsp_ready = 1; rnd_ops(); step();
        chk("t3_pulse_nogrant", 64'(obs0), 64'(0));
        r0_rsp_ready = 0; rnd_ops(); step();
        chk("t3_regrant", 64'(obs0), 64'(1));
        // full fifo: pop in the cycle the in-flight result pushes
        for (int i = 1; i < FPU_LAT; i++) begin step(); chk("t4_hold", 64'(obs0), 64'(0)); end
        r0_rsp_ready = 1; step();
        chk("t4_nogrant", 64'(obs0), 64'(0));
        r0_valid = 0; r0_rsp_ready = 0; step();
        r0_rsp_ready = 1; n0 = 0;
        repeat (6) begin step(); if (obsv0) n0++; end
        chk("t4_drain", 64'(n0), 64'(RSP_DEPTH - 1));
        // error path then normal op on r1
        idle_in(); r1_a = 32'hc0000000; r1_b = 32'h00000000; r1_sel = 2'b11; r1_valid = 1;
        step();
        chk("t5_hs", 64'(obs1), 64'(1));
        r1_a = 32'h3f800000; r1_b = 32'h40000000; r1_sel = 2'b00;
        for (int i = 1; i <= 9; i++) begin
            step();
            r1_valid = 0;
            if (obsv1) begin at.push_back(i); ad.push_back(oy1); end
        end
        chk("t5_cnt", 64'(at.size()), 64'(2));
        if (at.size() == 2) begin
            chk("t5_lat", 64'(at[0]), 64'(FPU_LAT + 1));
            chk("t5_err", 64'(ad[0][0]), 64'(1));
            chk("t5_next", 64'(ad[1]), 64'({32'h40400000, 2'b00}));
        end
        // randomized traffic
        for (int k = 0; k < 500; k++) begin
            rnd_ops();
            if ($urandom_range(0, 15) == 0) r0_b = 0;
            if ($urandom_range(0, 15) == 0) r1_b = 0;
            r0_valid = $urandom_range(0, 3) != 0;
            r1_valid = $urandom_range(0, 3) != 0;
            r0_rsp_ready = $urandom_range(0, 2) != 0;
            r1_rsp_ready = $urandom_range(0, 3) == 0;
            step();
        end
        idle_in();
        repeat (16) step();
        // reset with two ops in flight and one queued
        r0_rsp_ready = 0; r1_rsp_ready = 0; rnd_ops(); r0_valid = 1;
        step();
        r0_valid = 0;
        repeat (FPU_LAT + 1) step();
        r0_valid = 1; step();
        r0_valid = 0; r1_valid = 1; step();
        r0_valid = 1; r1_valid = 1; r0_rsp_ready = 1; r1_rsp_ready = 1;
        do_reset(0);
        n0 = 0;
        repeat (8) begin step(); if (obsv0 || obsv1) n0++; end
        chk("t6_norsp", 64'(n0), 64'(0));
        chk("t6_idle", 64'(oidle), 64'(1));
        r0_valid = 1; r1_valid = 1; step();
        chk("t6_first0", 64'(obs0), 64'(1));
        chk("t6_first1", 64'(obs1), 64'(0));
        idle_in();
        repeat (10) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
